// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store unit: handshaked RIB bus access with store lane alignment,
// load extraction, misalignment/illegal-size detection, bus-fault and timeout reporting.
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    output logic [3:0]        bus_sel_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_err_i,
    output logic              rsp_valid_o,
    output logic              rsp_we_o,
    output logic [4:0]        rsp_rd_o,
    output logic [31:0]       rsp_wdata_o,
    output logic              rsp_exc_o,
    output logic [2:0]        rsp_exc_code_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [2:0] EXC_LD_MIS  = 3'd0;
    localparam logic [2:0] EXC_ST_MIS  = 3'd1;
    localparam logic [2:0] EXC_LD_FLT  = 3'd2;
    localparam logic [2:0] EXC_ST_FLT  = 3'd3;
    localparam logic [2:0] EXC_TIMEOUT = 3'd4;
    localparam logic [2:0] EXC_ILL_SZ  = 3'd5;

    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);

    function automatic logic size_illegal(input logic we, input logic [2:0] f3);
        logic ill;
        if (we) begin
            ill = (f3 >= 3'd3);
        end else begin
            case (f3)
                3'd3, 3'd6, 3'd7: ill = 1'b1;
                default:          ill = 1'b0;
            endcase
        end
        return ill;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'd1:    mis = off[0];
            2'd2:    mis = (off != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_sel(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] sel;
        case (f3[1:0])
            2'd0:    sel = 4'b0001 << off;
            2'd1:    sel = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'h000000, b};
            3'd5:    r = {16'h0000, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_inc_s;
    logic              to_hit_s;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic [4:0]        rsp_rd_q, rsp_rd_d;
    logic [31:0]       rsp_wdata_q, rsp_wdata_d;
    logic              rsp_exc_q, rsp_exc_d;
    logic [2:0]        rsp_exc_code_q, rsp_exc_code_d;

    assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    // A zero limit means the timeout is disabled.
    assign to_hit_s  = (TO_LIM != {(CNT_W+1){1'b0}}) && (cnt_inc_s >= TO_LIM);

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        rd_d           = rd_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        bus_sel_d      = bus_sel_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_we_d       = rsp_we_q;
        rsp_rd_d       = rsp_rd_q;
        rsp_wdata_d    = rsp_wdata_q;
        rsp_exc_d      = rsp_exc_q;
        rsp_exc_code_d = rsp_exc_code_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d        = req_we_i;
                    funct3_d    = req_funct3_i;
                    off_d       = req_addr_i[1:0];
                    rd_d        = req_rd_i;
                    cnt_d       = {CNT_W{1'b0}};
                    rsp_rd_d    = req_rd_i;
                    rsp_we_d    = 1'b0;
                    rsp_wdata_d = 32'h0000_0000;
                    if (size_illegal(req_we_i, req_funct3_i)) begin
                        state_d        = S_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_exc_d      = 1'b1;
                        rsp_exc_code_d = EXC_ILL_SZ;
                    end else if (misaligned(req_funct3_i, req_addr_i[1:0])) begin
                        state_d        = S_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_exc_d      = 1'b1;
                        rsp_exc_code_d = req_we_i ? EXC_ST_MIS : EXC_LD_MIS;
                    end else begin
                        state_d     = S_ADDR;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we_i;
                        bus_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                        bus_wdata_d = store_data(req_funct3_i, req_wdata_i);
                        bus_sel_d   = store_sel(req_funct3_i, req_addr_i[1:0]);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                cnt_d = cnt_inc_s[CNT_W-1:0];
                if (bus_gnt_i) begin
                    state_d   = S_DATA;
                    bus_req_d = 1'b0;
                end else if (to_hit_s) begin
                    state_d        = S_RESP;
                    bus_req_d      = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_exc_d      = 1'b1;
                    rsp_exc_code_d = EXC_TIMEOUT;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                cnt_d = cnt_inc_s[CNT_W-1:0];
                // A response in the same cycle as the timeout still completes normally.
                if (bus_rvalid_i) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    if (bus_err_i) begin
                        rsp_exc_d      = 1'b1;
                        rsp_exc_code_d = we_q ? EXC_ST_FLT : EXC_LD_FLT;
                    end else begin
                        rsp_exc_d      = 1'b0;
                        rsp_exc_code_d = 3'd0;
                        rsp_we_d       = !we_q && (rd_q != 5'd0);
                        rsp_wdata_d    = we_q ? 32'h0000_0000
                                              : load_extract(funct3_q, off_q, bus_rdata_i);
                    end
                end else if (to_hit_s) begin
                    state_d        = S_RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_exc_d      = 1'b1;
                    rsp_exc_code_d = EXC_TIMEOUT;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                state_d        = S_IDLE;
                rsp_valid_d    = 1'b0;
                rsp_we_d       = 1'b0;
                rsp_rd_d       = 5'd0;
                rsp_wdata_d    = 32'h0000_0000;
                rsp_exc_d      = 1'b0;
                rsp_exc_code_d = 3'd0;
            end
            default: begin
                state_d     = S_IDLE;
                bus_req_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= {CNT_W{1'b0}};
            we_q           <= 1'b0;
            funct3_q       <= 3'd0;
            off_q          <= 2'd0;
            rd_q           <= 5'd0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= {ADDR_W{1'b0}};
            bus_wdata_q    <= 32'h0000_0000;
            bus_sel_q      <= 4'b0000;
            rsp_valid_q    <= 1'b0;
            rsp_we_q       <= 1'b0;
            rsp_rd_q       <= 5'd0;
            rsp_wdata_q    <= 32'h0000_0000;
            rsp_exc_q      <= 1'b0;
            rsp_exc_code_q <= 3'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            funct3_q       <= funct3_d;
            off_q          <= off_d;
            rd_q           <= rd_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            bus_sel_q      <= bus_sel_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_we_q       <= rsp_we_d;
            rsp_rd_q       <= rsp_rd_d;
            rsp_wdata_q    <= rsp_wdata_d;
            rsp_exc_q      <= rsp_exc_d;
            rsp_exc_code_q <= rsp_exc_code_d;
        end
    end

    assign req_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign bus_sel_o      = bus_sel_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_we_o       = rsp_we_q;
    assign rsp_rd_o       = rsp_rd_q;
    assign rsp_wdata_o    = rsp_wdata_q;
    assign rsp_exc_o      = rsp_exc_q;
    assign rsp_exc_code_o = rsp_exc_code_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with TIMEOUT=4; expected values are hand-computed.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;
    logic        rsp_valid_o;
    logic        rsp_we_o;
    logic [4:0]  rsp_rd_o;
    logic [31:0] rsp_wdata_o;
    logic        rsp_exc_o;
    logic [2:0]  rsp_exc_code_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_rd_o(rsp_rd_o),
        .rsp_wdata_o(rsp_wdata_o), .rsp_exc_o(rsp_exc_o), .rsp_exc_code_o(rsp_exc_code_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = d;
        req_rd_i     = rd;
        step();
        req_valid_i  = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic we, input logic [31:0] wdata,
                           input logic exc, input logic [2:0] code);
        chk({tag, "_valid"}, {31'd0, rsp_valid_o}, {31'd0, 1'b1});
        chk({tag, "_we"}, {31'd0, rsp_we_o}, {31'd0, we});
        chk({tag, "_wdata"}, rsp_wdata_o, wdata);
        chk({tag, "_exc"}, {31'd0, rsp_exc_o}, {31'd0, exc});
        if (exc) chk({tag, "_code"}, {29'd0, rsp_exc_code_o}, {29'd0, code});
    endtask

    // Grant next cycle, respond the cycle after, leaving the bench in RESP.
    task automatic bus_ok(input logic [31:0] rdata, input logic err);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
        bus_err_i    = err;
        step();
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; req_rd_i = 5'd0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;
        step();
        step();
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_bus_sel", {28'd0, bus_sel_o}, 32'd0);
        rst = 1'b0;
        step();

        // LB at 0x103: byte 0x80 sign-extended; response in cycle 3
        issue(1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd5);
        chk("lb_c1_req", {31'd0, bus_req_o}, 32'd1);
        chk("lb_c1_addr", bus_addr_o, 32'h0000_0100);
        chk("lb_c1_we", {31'd0, bus_we_o}, 32'd0);
        chk("lb_c1_ready", {31'd0, req_ready_o}, 32'd0);
        chk("lb_c1_busy", {31'd0, busy_o}, 32'd1);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        chk("lb_c2_req", {31'd0, bus_req_o}, 32'd0);
        chk("lb_c2_rspv", {31'd0, rsp_valid_o}, 32'd0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h80FF_1234;
        step();
        bus_rvalid_i = 1'b0;
        chk_rsp("lb_c3", 1'b1, 32'hFFFF_FF80, 1'b0, 3'd0);
        chk("lb_c3_rd", {27'd0, rsp_rd_o}, 32'd5);
        step();
        chk("lb_after_rspv", {31'd0, rsp_valid_o}, 32'd0);
        chk("lb_after_ready", {31'd0, req_ready_o}, 32'd1);

        // SH at 0x102 with a one-cycle grant delay
        issue(1'b1, 3'd1, 32'h0000_0102, 32'h0000_ABCD, 5'd0);
        chk("sh_sel", {28'd0, bus_sel_o}, 32'h0000_000C);
        chk("sh_wdata", bus_wdata_o, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, bus_we_o}, 32'd1);
        step();
        chk("sh_wait_req", {31'd0, bus_req_o}, 32'd1);
        bus_ok(32'hDEAD_BEEF, 1'b0);
        chk_rsp("sh_rsp", 1'b0, 32'h0, 1'b0, 3'd0);
        step();

        // SB at 0x101: lane 1, replicated byte
        issue(1'b1, 3'd0, 32'h0000_0101, 32'h1234_565A, 5'd0);
        chk("sb_sel", {28'd0, bus_sel_o}, 32'h0000_0002);
        chk("sb_wdata", bus_wdata_o, 32'h5A5A_5A5A);
        bus_ok(32'h0, 1'b1);
        chk_rsp("sb_err", 1'b0, 32'h0, 1'b1, 3'd3);
        step();

        // Misaligned and illegal-size requests never touch the bus
        issue(1'b0, 3'd2, 32'h0000_1001, 32'h0, 5'd7);
        chk("lw_mis_req", {31'd0, bus_req_o}, 32'd0);
        chk_rsp("lw_mis", 1'b0, 32'h0, 1'b1, 3'd0);
        step();
        chk("lw_mis_idle", {31'd0, req_ready_o}, 32'd1);
        issue(1'b1, 3'd2, 32'h0000_1002, 32'h0, 5'd0);
        chk_rsp("sw_mis", 1'b0, 32'h0, 1'b1, 3'd1);
        step();
        issue(1'b0, 3'd3, 32'h0000_2000, 32'h0, 5'd4);
        chk_rsp("ld_ill", 1'b0, 32'h0, 1'b1, 3'd5);
        step();
        issue(1'b1, 3'd4, 32'h0000_2000, 32'h0, 5'd0);
        chk_rsp("st_ill", 1'b0, 32'h0, 1'b1, 3'd5);
        step();

        // Timeout: grant withheld, bus_req high for exactly 4 cycles
        issue(1'b0, 3'd2, 32'h0000_0300, 32'h0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req_%0d", i), {31'd0, bus_req_o}, 32'd1);
            chk($sformatf("to_rspv_%0d", i), {31'd0, rsp_valid_o}, 32'd0);
            step();
        end
        chk("to_req_drop", {31'd0, bus_req_o}, 32'd0);
        chk_rsp("to_rsp", 1'b0, 32'h0, 1'b1, 3'd4);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1111_1111;
        step();
        chk("to_late_rspv", {31'd0, rsp_valid_o}, 32'd0);
        step();
        bus_rvalid_i = 1'b0;
        chk("to_late_idle", {31'd0, req_ready_o}, 32'd1);

        // Next request after timeout: LHU upper half zero-extended
        issue(1'b0, 3'd5, 32'h0000_0202, 32'h0, 5'd9);
        bus_ok(32'h8765_4321, 1'b0);
        chk_rsp("lhu_hi", 1'b1, 32'h0000_8765, 1'b0, 3'd0);
        step();

        // LH upper half sign-extended
        issue(1'b0, 3'd1, 32'h0000_0202, 32'h0, 5'd9);
        bus_ok(32'h8765_4321, 1'b0);
        chk_rsp("lh_hi", 1'b1, 32'hFFFF_8765, 1'b0, 3'd0);
        step();

        // LHU at 0x200 with bus fault
        issue(1'b0, 3'd5, 32'h0000_0200, 32'h0, 5'd6);
        bus_ok(32'h8765_4321, 1'b1);
        chk_rsp("lhu_err", 1'b0, 32'h0, 1'b1, 3'd2);
        step();

        // LW with rd=0 still returns data but never writes the GPR
        issue(1'b0, 3'd2, 32'h0000_0204, 32'h0, 5'd0);
        bus_ok(32'h1234_5678, 1'b0);
        chk_rsp("lw_rd0", 1'b0, 32'h1234_5678, 1'b0, 3'd0);
        step();

        // Grant and rvalid together: only the grant counts
        issue(1'b0, 3'd4, 32'h0000_0205, 32'h0, 5'd2);
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0000_AA00;
        step();
        bus_gnt_i = 1'b0;
        chk("gr_same_rspv", {31'd0, rsp_valid_o}, 32'd0);
        bus_rdata_i = 32'h0000_3300;
        step();
        bus_rvalid_i = 1'b0;
        chk_rsp("gr_same_rsp", 1'b1, 32'h0000_0033, 1'b0, 3'd0);
        step();

        // Timeout and rvalid in the same cycle: rvalid wins
        issue(1'b0, 3'd2, 32'h0000_0500, 32'h0, 5'd8);
        step();
        step();
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        step();
        bus_rvalid_i = 1'b0;
        chk_rsp("to_vs_rv", 1'b1, 32'hCAFE_F00D, 1'b0, 3'd0);
        step();

        // Reset while in DATA
        issue(1'b0, 3'd2, 32'h0000_0400, 32'h0, 5'd1);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstd_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rstd_busy", {31'd0, busy_o}, 32'd0);
        chk("rstd_req", {31'd0, bus_req_o}, 32'd0);
        chk("rstd_rspv", {31'd0, rsp_valid_o}, 32'd0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h5555_5555;
        step();
        bus_rvalid_i = 1'b0;
        chk("rstd_late_rspv", {31'd0, rsp_valid_o}, 32'd0);
        chk("rstd_late_busy", {31'd0, busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
